// File: rtl/vram_text_engine_pkg.sv
// Shared constants, command encodings and FSM states for the text-buffer engine.
package vram_text_engine_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0000_2000;
    localparam logic [31:0] CMD_ADDR  = 32'h0000_3000;
    localparam int unsigned COLS      = 64;
    localparam int unsigned ROWS      = 32;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IDX_W     = 11;
    localparam int unsigned FILL_W    = 8;
    localparam int unsigned CMD_W     = 2;

    // Last cell of the buffer, and last destination cell that is copied during a scroll
    localparam logic [IDX_W-1:0] IDX_LAST        = IDX_W'(COLS * ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_SCROLL_LAST = IDX_W'(COLS * (ROWS - 1) - 1);

    localparam logic [CMD_W-1:0] CMD_NOP    = 2'd0;
    localparam logic [CMD_W-1:0] CMD_CLEAR  = 2'd1;
    localparam logic [CMD_W-1:0] CMD_SCROLL = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        SRD  = 3'd2,
        SWR  = 3'd3,
        SFL  = 3'd4,
        FIN  = 3'd5
    } state_e;

endpackage

// File: rtl/vram_port_mux.sv
// Memory port A grant mux with command-register intercept and status read-back.
module vram_port_mux
    import vram_text_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic              cpu_wren,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] eng_addr,
    input  logic              eng_wren,
    input  logic [DATA_W-1:0] eng_wdata,
    input  logic              busy,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              eng_grant_c,
    output logic              cmd_valid_c,
    output logic [CMD_W-1:0]  cmd_code_c,
    output logic [FILL_W-1:0] cmd_fill_c
);

    logic is_cmd;
    logic status_sel;

    // CPU wins the port whenever it requests; command-register writes never reach memory
    always_comb begin
        is_cmd      = (cpu_addr == CMD_ADDR);
        eng_grant_c = !cpu_req;
        cmd_valid_c = cpu_req && cpu_wren && is_cmd;
        cmd_code_c  = cpu_wdata[1:0];
        cmd_fill_c  = cpu_wdata[15:8];
        if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_wren  = cpu_wren && !is_cmd;
            mem_wdata = cpu_wdata;
        end else begin
            mem_addr  = eng_addr;
            mem_wren  = eng_wren;
            mem_wdata = eng_wdata;
        end
    end

    // Status read data appears one cycle after the read, aligned with memory q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_sel <= 1'b0;
        end else begin
            status_sel <= cpu_req && !cpu_wren && is_cmd;
        end
    end

    // Read-data return: status flag or memory q
    always_comb begin
        cpu_rdata = status_sel ? {31'b0, busy} : mem_rdata;
    end

endmodule

// File: rtl/vram_text_engine.sv
// CPU/memory port controller with background clear and scroll of the 64x32 text buffer.
module vram_text_engine
    import vram_text_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic              cpu_wren,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    state_e              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [FILL_W-1:0]   fill, fill_nxt;
    logic [DATA_W-1:0]   copy_buf, copy_nxt;
    logic                swr_first, swr_first_nxt;
    logic                busy_nxt, done_nxt;

    logic [DATA_W-1:0]   eng_addr;
    logic                eng_wren;
    logic [DATA_W-1:0]   eng_wdata;
    logic                eng_grant_c;
    logic                cmd_valid_c;
    logic [CMD_W-1:0]    cmd_code_c;
    logic [FILL_W-1:0]   cmd_fill_c;

    vram_port_mux u_port_mux (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_wren    (cpu_wren),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .eng_addr    (eng_addr),
        .eng_wren    (eng_wren),
        .eng_wdata   (eng_wdata),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .eng_grant_c (eng_grant_c),
        .cmd_valid_c (cmd_valid_c),
        .cmd_code_c  (cmd_code_c),
        .cmd_fill_c  (cmd_fill_c)
    );

    // Engine state, index, fill and copy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            fill      <= '0;
            copy_buf  <= '0;
            swr_first <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            fill      <= fill_nxt;
            copy_buf  <= copy_nxt;
            swr_first <= swr_first_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and engine port request; progress happens only on granted cycles
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        fill_nxt      = fill;
        copy_nxt      = copy_buf;
        swr_first_nxt = 1'b0;
        eng_addr      = '0;
        eng_wren      = 1'b0;
        eng_wdata     = '0;

        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (cmd_valid_c && (cmd_code_c == CMD_CLEAR)) begin
                    fill_nxt  = cmd_fill_c;
                    state_nxt = CLR;
                end else if (cmd_valid_c && (cmd_code_c == CMD_SCROLL)) begin
                    fill_nxt  = cmd_fill_c;
                    state_nxt = SRD;
                end
            end
            CLR, SFL: begin
                eng_addr  = TEXT_BASE + DATA_W'(idx);
                eng_wren  = 1'b1;
                eng_wdata = {24'b0, fill};
                if (eng_grant_c) begin
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_nxt = FIN;
                    end
                end
            end
            SRD: begin
                eng_addr = TEXT_BASE + DATA_W'({1'b0, idx} + 12'(COLS));
                if (eng_grant_c) begin
                    state_nxt     = SWR;
                    swr_first_nxt = 1'b1;
                end
            end
            SWR: begin
                // Memory q is only ours in the first SWR cycle; keep it for later grants
                if (swr_first) begin
                    copy_nxt = mem_rdata;
                end
                eng_addr  = TEXT_BASE + DATA_W'(idx);
                eng_wren  = 1'b1;
                eng_wdata = swr_first ? mem_rdata : copy_buf;
                if (eng_grant_c) begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = (idx == IDX_SCROLL_LAST) ? SFL : SRD;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == CLR) || (state_nxt == SRD) ||
                   (state_nxt == SWR) || (state_nxt == SFL);
        done_nxt = (state_nxt == FIN);
    end

endmodule
